lifo_stack: RTL and testbench

- Parametrised successor to the 2-bit, 16-deep control stack.
- Synchronous LIFO with any data width and depth, and an occupancy count.
- Adds programmable almost-full/almost-empty flags, simultaneous push+pop (replace top), synchronous clear and sticky overflow/underflow error flags.
- Used by the control path for return addresses and nested-state save/restore.
- TOP always presents the current top-of-stack, so a pop needs no extra read cycle.

---
 rtl/stack_pkg.sv | 31 +++
 rtl/stack_ram.sv | 26 ++
 rtl/lifo_stack.sv | 124 ++++++++++++
 tb/tb_lifo_stack.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op encoding and default flag margins for the lifo stack
package stack_pkg;

    // One decoded operation per clock edge
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

    // ALMOST_FULL default sits this many entries below DEPTH
    localparam int AFULL_MARGIN   = 2;
    // ALMOST_EMPTY default threshold
    localparam int AEMPTY_DEFAULT = 1;

    // Maps the raw request pair to an operation; a push+pop on an empty stack is a plain push
    function automatic stack_op_e decode_op(input logic push, input logic pop, input logic empty);
        stack_op_e op;
        op = OP_NOP;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x DATA_WIDTH storage, one synchronous write port, one asynchronous read port
module stack_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents are deliberately left unreset
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with registered top, occupancy and status flags
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - AFULL_MARGIN,
    parameter int AEMPTY_LEVEL = AEMPTY_DEFAULT,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] TOP,
    output logic [CW-1:0]         COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    stack_op_e             op;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] top_nxt;
    logic                  ovf_nxt;
    logic                  udf_nxt;
    logic                  ram_we;
    logic [CW-1:0]         waddr_w;
    logic [CW-1:0]         raddr_w;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Refill source for a pop: the entry just below the current top
    assign raddr_w = (COUNT >= CW'(2)) ? (COUNT - CW'(2)) : '0;

    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (waddr_w[AW-1:0]),
        .wdata (DATA_IN),
        .raddr (raddr_w[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Decode the request and compute next occupancy, top, error flags and the storage write
    always_comb begin
        op        = decode_op(PUSH, POP, COUNT == '0);
        count_nxt = COUNT;
        top_nxt   = TOP;
        ovf_nxt   = OVERFLOW;
        udf_nxt   = UNDERFLOW;
        ram_we    = 1'b0;
        waddr_w   = COUNT;
        if (CLR) begin
            count_nxt = '0;
            top_nxt   = '0;
            ovf_nxt   = 1'b0;
            udf_nxt   = 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (COUNT < DEPTH_C) begin
                        ram_we    = 1'b1;
                        waddr_w   = COUNT;
                        count_nxt = COUNT + CW'(1);
                        top_nxt   = DATA_IN;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
                OP_POP: begin
                    if (COUNT != '0) begin
                        count_nxt = COUNT - CW'(1);
                        top_nxt   = (COUNT >= CW'(2)) ? ram_rdata : '0;
                    end else begin
                        udf_nxt = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    ram_we  = 1'b1;
                    waddr_w = COUNT - CW'(1);
                    top_nxt = DATA_IN;
                end
                default: begin
                end
            endcase
        end
    end

    // State and flag registers; flags derive from the next count so they are never stale
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            COUNT        <= '0;
            TOP          <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
            COUNT        <= count_nxt;
            TOP          <= top_nxt;
            FULL         <= (count_nxt == DEPTH_C);
            EMPTY        <= (count_nxt == '0);
            ALMOST_FULL  <= (int'(count_nxt) >= AFULL_LEVEL);
            ALMOST_EMPTY <= (int'(count_nxt) <= AEMPTY_LEVEL);
            OVERFLOW     <= ovf_nxt;
            UNDERFLOW    <= udf_nxt;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - randomized and directed self-checking bench for lifo_stack
module tb_lifo_stack;
    import stack_pkg::*;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);
    localparam int AFL = 3;
    localparam int AEL = 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          CLR = 1'b0;
    logic          PUSH = 1'b0;
    logic          POP = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic [DW-1:0] TOP;
    logic [CW-1:0] COUNT;
    logic          FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

    lifo_stack #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DP),
        .AFULL_LEVEL  (AFL),
        .AEMPTY_LEVEL (AEL)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .CLR          (CLR),
        .PUSH         (PUSH),
        .POP          (POP),
        .DATA_IN      (DATA_IN),
        .TOP          (TOP),
        .COUNT        (COUNT),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_q[$];
    bit            m_ovf = 0;
    bit            m_udf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic model_step(input bit clr, input bit push, input bit pop, input logic [DW-1:0] d);
        stack_op_e op;
        if (clr) begin
            model_reset();
            return;
        end
        op = decode_op(push, pop, m_q.size() == 0);
        case (op)
            OP_PUSH:    if (m_q.size() < DP) m_q.push_back(d); else m_ovf = 1;
            OP_POP:     if (m_q.size() > 0) void'(m_q.pop_back()); else m_udf = 1;
            OP_REPLACE: m_q[m_q.size()-1] = d;
            default:    ;
        endcase
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        check({tag, ".count"}, 32'(COUNT), 32'(n));
        check({tag, ".top"}, 32'(TOP), (n > 0) ? 32'(m_q[n-1]) : 32'd0);
        check({tag, ".full"}, 32'(FULL), 32'(n == DP));
        check({tag, ".empty"}, 32'(EMPTY), 32'(n == 0));
        check({tag, ".afull"}, 32'(ALMOST_FULL), 32'(n >= AFL));
        check({tag, ".aempty"}, 32'(ALMOST_EMPTY), 32'(n <= AEL));
        check({tag, ".ovf"}, 32'(OVERFLOW), 32'(m_ovf));
        check({tag, ".udf"}, 32'(UNDERFLOW), 32'(m_udf));
    endtask

    task automatic step(input string tag, input bit clr, input bit push, input bit pop,
                        input logic [DW-1:0] d);
        @(negedge CLK);
        CLR = clr;
        PUSH = push;
        POP = pop;
        DATA_IN = d;
        @(posedge CLK);
        #1;
        model_step(clr, push, pop, d);
        check_all(tag);
        @(negedge CLK);
        CLR = 0;
        PUSH = 0;
        POP = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // async reset mid-stream
        step("pre_rst1", 0, 1, 0, 8'h11);
        step("pre_rst2", 0, 1, 0, 8'h22);
        #2;
        RST_N = 1'b0;
        PUSH = 1'b1;
        DATA_IN = 8'h77;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge CLK);
        #1;
        check_all("rst_held");
        @(negedge CLK);
        PUSH = 1'b0;
        RST_N = 1'b1;
        step("pop_empty", 0, 0, 1, 8'h00);
        check("udf_set", 32'(UNDERFLOW), 32'd1);
        step("clr0", 1, 0, 0, 8'h00);

        // fill, flags, overflow
        step("push11", 0, 1, 0, 8'h11);
        step("push22", 0, 1, 0, 8'h22);
        check("aempty_off_at2", 32'(ALMOST_EMPTY), 32'd0);
        step("push33", 0, 1, 0, 8'h33);
        check("afull_at3", 32'(ALMOST_FULL), 32'd1);
        step("push44", 0, 1, 0, 8'h44);
        check("top44", 32'(TOP), 32'h44);
        check("full4", 32'(FULL), 32'd1);
        step("push55", 0, 1, 0, 8'h55);
        check("ovf_top44", 32'(TOP), 32'h44);
        check("ovf_set", 32'(OVERFLOW), 32'd1);

        // replace at full, then drain
        step("clr1", 1, 0, 0, 8'h00);
        for (int i = 1; i <= 4; i++) step("refill", 0, 1, 0, 8'(i * 8'h11));
        step("repl_full", 0, 1, 1, 8'h99);
        check("repl_top", 32'(TOP), 32'h99);
        check("repl_no_ovf", 32'(OVERFLOW), 32'd0);
        step("pop1", 0, 0, 1, 8'h00);
        check("pop1_top", 32'(TOP), 32'h33);
        step("pop2", 0, 0, 1, 8'h00);
        step("pop3", 0, 0, 1, 8'h00);
        check("pop3_top", 32'(TOP), 32'h11);
        step("pop4", 0, 0, 1, 8'h00);
        check("pop4_top", 32'(TOP), 32'h00);
        check("pop4_empty", 32'(EMPTY), 32'd1);

        // push+pop on empty is a push
        step("pp_empty", 0, 1, 1, 8'h5A);
        check("pp_empty_top", 32'(TOP), 32'h5A);
        check("pp_empty_udf", 32'(UNDERFLOW), 32'd0);

        // CLR wins over PUSH
        step("f2", 0, 1, 0, 8'hA1);
        step("f3", 0, 1, 0, 8'hA2);
        step("f4", 0, 1, 0, 8'hA3);
        step("f5", 0, 1, 0, 8'hA4);
        step("f6", 0, 0, 1, 8'h00);
        check("pre_clr_count", 32'(COUNT), 32'd3);
        step("clr_push", 1, 1, 0, 8'hEE);
        check("clr_count", 32'(COUNT), 32'd0);
        check("clr_ovf", 32'(OVERFLOW), 32'd0);
        step("push01", 0, 1, 0, 8'h01);
        check("top01", 32'(TOP), 32'h01);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            bit c, pu, po;
            c  = ($urandom_range(99) < 3);
            pu = $urandom_range(1);
            po = $urandom_range(1);
            step("rand", c, pu, po, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
